irq_controller: RTL
===================

# irq_controller

Memory-mapped interrupt controller that sits directly upstream of the `armreduced` core and drives its active-low `nIRQ` input. It latches up to NUM_SRC peripheral interrupt requests, applies per-source enables and a global enable, and resolves them by fixed priority. A claim/end-of-interrupt FSM holds `nIRQ` low only until software claims the request. It hangs on the core's data bus (`memaddr`/`memwrite`/`writedata`) and returns read data combinationally, so single-cycle loads complete in the same cycle.

## Interface
- NUM_SRC, 8: number of interrupt sources, 1..32.
- BASE_ADDR, 32'hFFFF_0000: byte address of register 0; the block decodes a 32-byte window.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- irq_src  input  NUM_SRC  request lines, synchronous to clk, active high.
- memaddr  input  32  core data address.
- memwrite  input  1  core write strobe.
- writedata  input  32  core write data.
- irq_sel  output  1  combinational; high when memaddr[31:5]==BASE_ADDR[31:5]; the system read mux selects irq_rdata.
- irq_rdata  output  32  combinational register read data; 0 when not selected.
- nIRQ  output  1  registered, active low, to core.

## Operation
- Registers, word offsets; unused bits read 0. memread is ignored, and reads have no side effects.
  - 0x00 RAW, RO: irq_src sampled this cycle.
  - 0x04 ENABLE, RW: per-source enable.
  - 0x08 PENDING, RO: latched pending bits.
  - 0x0C ID, RO: bit31 = any (PENDING & ENABLE); [4:0] = lowest-index set bit of PENDING & ENABLE, else 0. Any write = CLAIM.
  - 0x10 EOI, WO: writedata[4:0] = ID being completed; reads 0.
  - 0x14 CTRL, RW: bit0 global enable GEN.
  - 0x18 ACTIVE, RO: bit31 = in service; [4:0] = in-service ID.
  - 0x1C reserved: reads 0, writes ignored.
- Priority: lowest index highest. Bits ≥ NUM_SRC are forced 0.
- Pending set: see Configuration. Pending for source k clears only on CLAIM of k.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE→REQ: GEN=1 and |(PENDING & ENABLE).
  - REQ→SERVICE on CLAIM. Latch ACTIVE id = current ID[4:0] and clear that PENDING bit.
  - REQ→IDLE if GEN=0 or (PENDING & ENABLE)==0.
  - SERVICE→IDLE on an EOI write whose [4:0] equals the active id. A mismatched EOI is ignored.
  - CLAIM in IDLE/SERVICE is ignored; EOI in IDLE/REQ is ignored.
- nIRQ = 0 exactly when state==REQ (registered output).
- Simultaneous events:
  - New set on source k in the same cycle as the CLAIM clearing k: set wins and k stays pending.
  - Writing ENABLE/GEN in the same cycle as CLAIM: the claim uses the pre-write values.

## Timing
- Reset: state IDLE, ENABLE=0, PENDING=0, GEN=0, ACTIVE=0, edge history=0, nIRQ=1; irq_sel and irq_rdata follow memaddr combinationally.
- Reset asserted mid-operation returns everything to reset values immediately; nIRQ goes high asynchronously.
- Source set at rising edge N, so PENDING is visible after N. The FSM enters REQ at N+1 and nIRQ is low after N+1 (2-edge latency).
- CLAIM write at edge M: nIRQ high after M, and ACTIVE/PENDING update at M.
- Matching EOI at edge E gives IDLE after E. A further eligible pending source re-asserts nIRQ after E+1.
- The core updates its PC on negedge clk, so bus signals are stable at posedge; no additional handshake.

## Configuration
- IRQCTRL_EDGE_EN defined:
  - Rising-edge detect per source (irq_src & ~prev), which sets PENDING.
  - A held-high source sets PENDING once per edge.
  - prev register resets to 0, so a source high at reset release counts as an edge on the first clock.
- Undefined (level mode):
  - PENDING is set every cycle that irq_src[k]=1, so a held source re-pends immediately after CLAIM.
  - No prev register.

## Test plan
- Reset then ENABLE=0x01, GEN=1; pulse irq_src[0] for 1 cycle → PENDING=0x01 and nIRQ low 2 edges after the pulse; ID reads 0x8000_0000.
- Sources 2 and 5 set together, ENABLE=0xFF → ID=0x8000_0002. CLAIM → ACTIVE=0x8000_0002 and nIRQ high. EOI(5) is ignored. EOI(2) → nIRQ low again with ID=0x8000_0005.
- Source 3 pending, ENABLE=0x00 → nIRQ stays high. Write ENABLE=0x08 → nIRQ low after 2 edges. Write GEN=0 in REQ → nIRQ high next edge.
- Edge build: CLAIM source 1 while irq_src[1] has a new rising edge the same cycle → PENDING[1] remains 1. Level build: hold irq_src[1] high, CLAIM then EOI → nIRQ re-asserts.
- Assert reset while in SERVICE → nIRQ=1, ACTIVE=0, PENDING=0, and ENABLE/CTRL read 0 without a clock edge.
- memaddr=BASE_ADDR+0x1C and memaddr=BASE_ADDR-4 → irq_rdata=0; irq_sel=1 and 0 respectively; writes change no state.

Source files
------------

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - fixed-priority interrupt controller driving the core's active-low nIRQ
//
// Purpose: latches up to NUM_SRC interrupt requests, masks them with per-source
// enables and a global enable, resolves by fixed priority (lowest index wins)
// and runs an IDLE/REQ/SERVICE claim/EOI handshake that holds nIRQ low only in REQ.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous active-high reset
//   irq_src    [NUM_SRC] request lines, active high
//   memaddr    [32] core data address
//   memwrite   core write strobe
//   writedata  [32] core write data
//   irq_sel    high when memaddr falls in the 32-byte register window
//   irq_rdata  [32] combinational read data, 0 when not selected
//   nIRQ       registered active-low interrupt request to the core
//
// Build option: define IRQCTRL_EDGE_EN for rising-edge capture of irq_src;
// otherwise every cycle a source is high sets its pending bit (level mode).

module irq_controller #(
    parameter int          NUM_SRC   = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [31:0]        memaddr,
    input  logic               memwrite,
    input  logic [31:0]        writedata,
    output logic               irq_sel,
    output logic [31:0]        irq_rdata,
    output logic               nIRQ
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    localparam logic [31:0] SRC_MASK = (NUM_SRC >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << NUM_SRC) - 32'd1);

    state_t      state, state_n;
    logic [31:0] enable;
    logic [31:0] pending;
    logic        gen;
    logic        active_valid;
    logic [4:0]  active_id;
    logic        nirq_q;

    logic [31:0] src32;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;
    logic [31:0] eligible;
    logic        any_el;
    logic [4:0]  cur_id;
    logic [2:0]  off;
    logic        wr;
    logic        claim_wr;
    logic        eoi_wr;
    logic        claim_ok;
    logic        eoi_ok;
    logic [1:0]  unused_addr_bits;

    assign unused_addr_bits = memaddr[1:0];

    always_comb begin
        src32 = '0;
        src32[NUM_SRC-1:0] = irq_src;
    end

`ifdef IRQCTRL_EDGE_EN
    // prev starts at 0, so a source already high when reset releases counts as an edge.
    logic [31:0] prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= '0;
        else       prev <= src32;
    end

    assign set_vec = src32 & ~prev;
`else
    assign set_vec = src32;
`endif

    assign irq_sel  = (memaddr[31:5] == BASE_ADDR[31:5]);
    assign off      = memaddr[4:2];
    assign wr       = irq_sel && memwrite;
    assign claim_wr = wr && (off == 3'd3);
    assign eoi_wr   = wr && (off == 3'd4);

    assign eligible = pending & enable;
    assign any_el   = |eligible;

    // Scan high to low so the lowest set index is the one left in cur_id.
    always_comb begin
        cur_id = '0;
        for (int i = 31; i >= 0; i--) begin
            if (eligible[i]) cur_id = 5'(i);
        end
    end

    always_comb begin
        state_n  = state;
        claim_ok = 1'b0;
        eoi_ok   = 1'b0;
        unique case (state)
            IDLE: begin
                if (gen && any_el) state_n = REQ;
            end
            REQ: begin
                // Losing eligibility takes precedence; a claim then has nothing to take.
                if (!gen || !any_el) begin
                    state_n = IDLE;
                end else if (claim_wr) begin
                    claim_ok = 1'b1;
                    state_n  = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi_wr && (writedata[4:0] == active_id)) begin
                    eoi_ok  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign clr_vec = claim_ok ? (32'd1 << cur_id) : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            nirq_q       <= 1'b1;
            enable       <= '0;
            pending      <= '0;
            gen          <= 1'b0;
            active_valid <= 1'b0;
            active_id    <= '0;
        end else begin
            state   <= state_n;
            nirq_q  <= (state_n != REQ);
            // A new set on the claimed source in the same cycle wins over the clear.
            pending <= ((pending & ~clr_vec) | set_vec) & SRC_MASK;
            if (wr && (off == 3'd1)) enable <= writedata & SRC_MASK;
            if (wr && (off == 3'd5)) gen    <= writedata[0];
            if (claim_ok) begin
                active_valid <= 1'b1;
                active_id    <= cur_id;
            end else if (eoi_ok) begin
                active_valid <= 1'b0;
                active_id    <= '0;
            end
        end
    end

    assign nIRQ = nirq_q;

    always_comb begin
        irq_rdata = '0;
        if (irq_sel) begin
            unique case (off)
                3'd0: irq_rdata = src32;
                3'd1: irq_rdata = enable;
                3'd2: irq_rdata = pending;
                3'd3: irq_rdata = {any_el, 26'd0, cur_id};
                3'd4: irq_rdata = '0;
                3'd5: irq_rdata = {31'd0, gen};
                3'd6: irq_rdata = {active_valid, 26'd0, active_id};
                3'd7: irq_rdata = '0;
                default: irq_rdata = '0;
            endcase
        end
    end

endmodule
